// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle Booth signed multiply and restoring signed divide.
// Result packs {HI, LO} = product, or {remainder, quotient} for Div.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               start,
   input  logic [4:0]         opcode,
   input  logic [WIDTH-1:0]   Ra,
   input  logic [WIDTH-1:0]   Rb,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] Rc,
   output logic               div_by_zero
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [4:0] OP_MUL = 5'b01101;
   localparam logic [4:0] OP_DIV = 5'b01100;
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH:0]     a_q, a_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic               qm1_q, qm1_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic               sa_q, sa_d;
   logic               sb_q, sb_d;
   logic [2*WIDTH-1:0] rc_q, rc_d;
   logic               dbz_q, dbz_d;
   logic               accept, last, is_mul;
   logic [WIDTH:0]     m_ext, booth_sum, booth_a;
   logic [WIDTH-1:0]   booth_q;
   logic [WIDTH:0]     div_sh, div_diff, div_a;
   logic [WIDTH-1:0]   div_q, quo_s, rem_s, ra_raw;
   // All operand and result registers share one async-cleared register process.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         m_q     <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         rc_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         m_q     <= m_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         rc_q    <= rc_d;
         dbz_q   <= dbz_d;
      end
   end
   always_comb begin
      is_mul  = opcode == OP_MUL;
      accept  = state_q == IDLE && start && (is_mul || opcode == OP_DIV);
      last    = cnt_q == CNT_LAST;
      state_d = state_q == IDLE ? (accept ? (is_mul ? MUL : DIV) : IDLE) :
                state_q == MUL  ? (last ? DONE : MUL) :
                state_q == DIV  ? ((m_q == '0 || last) ? DONE : DIV) : IDLE;
   end
   always_comb begin
      busy        = state_q == MUL || state_q == DIV;
      done        = state_q == DONE;
      Rc          = rc_q;
      div_by_zero = dbz_q;
   end
   // Booth step on {A, Q, q-1}; A carries one guard bit so -2^(W-1) never overflows.
   always_comb begin
      m_ext     = {m_q[WIDTH-1], m_q};
      booth_sum = (q_q[0] && !qm1_q) ? a_q - m_ext :
                  (!q_q[0] && qm1_q) ? a_q + m_ext : a_q;
      booth_a   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      booth_q   = {booth_sum[0], q_q[WIDTH-1:1]};
      div_sh    = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
      div_diff  = div_sh - {1'b0, m_q};
      div_a     = div_diff[WIDTH] ? div_sh : div_diff;
      div_q     = {q_q[WIDTH-2:0], ~div_diff[WIDTH]};
      quo_s     = (sa_q ^ sb_q) ? -div_q : div_q;
      rem_s     = sa_q ? -div_a[WIDTH-1:0] : div_a[WIDTH-1:0];
      ra_raw    = sa_q ? -q_q : q_q;
   end
   always_comb begin
      cnt_d = cnt_q;
      a_d   = a_q;
      q_d   = q_q;
      qm1_d = qm1_q;
      m_d   = m_q;
      sa_d  = sa_q;
      sb_d  = sb_q;
      rc_d  = rc_q;
      dbz_d = dbz_q;
      if (accept) begin
         cnt_d = '0;
         a_d   = '0;
         qm1_d = 1'b0;
         dbz_d = 1'b0;
         sa_d  = Ra[WIDTH-1];
         sb_d  = Rb[WIDTH-1];
         q_d   = is_mul ? Rb : (Ra[WIDTH-1] ? -Ra : Ra);
         m_d   = is_mul ? Ra : (Rb[WIDTH-1] ? -Rb : Rb);
      end else if (state_q == MUL) begin
         cnt_d = cnt_q + 1'b1;
         a_d   = booth_a;
         q_d   = booth_q;
         qm1_d = q_q[0];
         if (last) rc_d = {booth_a[WIDTH-1:0], booth_q};
      end else if (state_q == DIV && m_q == '0) begin
         rc_d  = {ra_raw, {WIDTH{1'b1}}};
         dbz_d = 1'b1;
      end else if (state_q == DIV) begin
         cnt_d = cnt_q + 1'b1;
         a_d   = div_a;
         q_d   = div_q;
         if (last) rc_d = {rem_s, quo_s};
      end
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: table-driven vectors plus hand sequences, results
// checked through a scoreboard queue popped on each done pulse.
module tb_muldiv_sequencer;
   localparam logic [4:0] OP_MUL = 5'b01101;
   localparam logic [4:0] OP_DIV = 5'b01100;
   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] rc;
      logic        dbz;
      int          lat;
   } vec_t;
   typedef struct {
      logic [63:0] rc;
      logic        dbz;
      int          lat;
   } exp_t;
   logic        clock = 1'b0;
   logic        clear = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  opcode = '0;
   logic [31:0] Ra = '0;
   logic [31:0] Rb = '0;
   logic        busy, done, div_by_zero;
   logic [63:0] Rc;
   int          passed = 0;
   int          total = 0;
   exp_t        sb[$];
   vec_t        vecs[8];
   logic [63:0] last_rc = '0;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clock(clock), .clear(clear), .start(start), .opcode(opcode),
      .Ra(Ra), .Rb(Rb), .busy(busy), .done(done), .Rc(Rc),
      .div_by_zero(div_by_zero)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Launch one op, poke a foreign start at cycle `poke` (negative = never), wait for done.
   task automatic run(input string name, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] rc, input logic dbz,
                      input int lat, input int poke);
      exp_t e;
      int   k;
      logic busy_ok;
      e.rc = rc; e.dbz = dbz; e.lat = lat;
      sb.push_back(e);
      start = 1'b1; opcode = op; Ra = a; Rb = b;
      @(posedge clock); #1;
      start = 1'b0; Ra = $urandom; Rb = $urandom;
      busy_ok = busy && !done && !div_by_zero;
      k = 0;
      while (!done && k < 100) begin
         if (k == poke) begin start = 1'b1; opcode = OP_MUL; Ra = 32'd3; Rb = 32'd9; end
         else start = 1'b0;
         @(posedge clock); #1;
         k++;
         if (!done && !busy) busy_ok = 1'b0;
      end
      start = 1'b0;
      e = sb.pop_front();
      chk({name, " busy"}, 64'(busy_ok), 64'd1);
      chk({name, " latency"}, 64'(k), 64'(e.lat));
      chk({name, " Rc"}, Rc, e.rc);
      chk({name, " dbz"}, 64'(div_by_zero), 64'(e.dbz));
      last_rc = e.rc;
      @(posedge clock); #1;
      chk({name, " pulse"}, {62'd0, done, busy}, 64'd0);
   endtask

   initial begin
      vecs[0] = '{OP_MUL, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 1'b0, 32};
      vecs[1] = '{OP_MUL, 32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0, 32};
      vecs[2] = '{OP_MUL, 32'hFFFFFFFF, 32'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 32};
      vecs[3] = '{OP_DIV, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 32};
      vecs[4] = '{OP_DIV, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 32};
      vecs[5] = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 1'b0, 32};
      vecs[6] = '{OP_DIV, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 1'b1, 1};
      vecs[7] = '{OP_DIV, 32'h7FFFFFFF, 32'hFFFFFFF0, {32'd15, 32'hF8000001}, 1'b0, 32};
      #1;
      chk("reset outputs", {busy, done, div_by_zero, Rc[60:0]}, 64'd0);
      chk("reset Rc", Rc, 64'd0);
      #13 clear = 1'b0;
      @(posedge clock); #1;
      foreach (vecs[i]) run($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                            vecs[i].rc, vecs[i].dbz, vecs[i].lat, -1);
      // Model-based checks with random operands, avoiding zero divisor and overflow.
      for (int i = 0; i < 6; i++) begin
         logic signed [31:0] a, b;
         logic signed [63:0] p;
         logic signed [31:0] qq, rr;
         a = $urandom; b = $urandom;
         if (i[0]) b = b >>> 20;
         if (b == 0) b = 32'sd3;
         p = 64'(a) * 64'(b);
         run($sformatf("rmul%0d", i), OP_MUL, a, b, p, 1'b0, 32, -1);
         if (b == -1 && a == 32'sh80000000) a = 32'sd1;
         qq = a / b; rr = a % b;
         run($sformatf("rdiv%0d", i), OP_DIV, a, b, {rr, qq}, 1'b0, 32, -1);
      end
      // Illegal opcode in IDLE is ignored.
      start = 1'b1; opcode = 5'b00000; Ra = 32'd1; Rb = 32'd2;
      @(posedge clock); #1;
      start = 1'b0;
      chk("illegal busy", {62'd0, busy, done}, 64'd0);
      chk("illegal Rc hold", Rc, last_rc);
      // div_by_zero set, then drops as soon as the next op is accepted.
      run("dbz2", OP_DIV, 32'hFFFFFFFE, 32'd0, {32'hFFFFFFFE, 32'hFFFFFFFF}, 1'b1, 1, -1);
      chk("dbz held in idle", 64'(div_by_zero), 64'd1);
      // Foreign start mid-multiply is ignored.
      run("poke", OP_MUL, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 1'b0, 32, 10);
      // Async clear during iteration 15 of a divide.
      start = 1'b1; opcode = OP_DIV; Ra = 32'd100; Rb = 32'd7;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (15) @(posedge clock);
      #3 clear = 1'b1;
      #1;
      chk("abort busy/done/dbz", {61'd0, busy, done, div_by_zero}, 64'd0);
      chk("abort Rc", Rc, 64'd0);
      @(negedge clock) clear = 1'b0;
      @(posedge clock); #1;
      run("post-abort mul", OP_MUL, 32'd6, 32'd6, 64'd36, 1'b0, 32, -1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
